// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the core-side
// instruction handshake and redirect inputs.
interface fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic            pcjump;
    logic [XLEN-1:0] jump_target;
    logic            misalign;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, misalign,
        input  imem_rvalid, imem_rdata, inst_ready, pcjump, jump_target
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, misalign,
        output imem_rvalid, imem_rdata, inst_ready, pcjump, jump_target
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, one outstanding imem read, buffered
// instruction with valid/ready. Optional misaligned-jump trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        TRAP  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            capture;
    logic            handshake;
    logic            jump_misaligned;

    // Redirect address: JALR clears bit 0; without the trap, bit 1 is dropped too.
    function automatic logic [XLEN-1:0] redirect_pc(input logic [XLEN-1:0] target);
`ifdef FETCH_MISALIGN_TRAP_EN
        return target & ~XLEN'(1);
`else
        return target & ~XLEN'(3);
`endif
    endfunction

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur,
                                                input logic            jump,
                                                input logic [XLEN-1:0] target);
        if (jump)
            return redirect_pc(target);
        return cur + XLEN'(4);
    endfunction

    assign handshake = (state == HOLD) && bus.inst_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign jump_misaligned = bus.pcjump && bus.jump_target[1];
`else
    assign jump_misaligned = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        case (state)
            BOOT:  state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (bus.imem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    pc_nxt    = next_pc(pc, bus.pcjump, bus.jump_target);
                    state_nxt = jump_misaligned ? TRAP : ISSUE;
                end
            end
            TRAP:    state_nxt = TRAP;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Instruction buffer holds its word and fetch address until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else if (capture) begin
            inst_q    <= bus.imem_rdata;
            inst_pc_q <= pc;
        end
    end

    assign bus.imem_req   = (state == ISSUE);
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = (state == HOLD);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misalign = (state == TRAP);
`else
    assign bus.misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: event-level reference model compared every
// negedge, plus directed scenarios with literal expectations.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be after the next rising edge.
    logic        m_boot, m_req, m_out, m_valid, m_mis;
    logic [31:0] m_pc, m_inst, m_ipc;

    function automatic logic [31:0] model_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return {t[31:1], 1'b0};
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    function automatic logic model_traps(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return t[1];
`else
        return 1'b0 & t[1];
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_boot  = 1'b1;
            m_req   = 1'b0;
            m_out   = 1'b0;
            m_valid = 1'b0;
            m_mis   = 1'b0;
            m_pc    = RST_PC;
            m_inst  = 32'h0;
            m_ipc   = 32'h0;
        end
        check("cyc imem_req",   32'(bus.imem_req),   32'(m_req));
        check("cyc imem_addr",  bus.imem_addr,       m_pc);
        check("cyc inst_valid", 32'(bus.inst_valid), 32'(m_valid));
        check("cyc inst",       bus.inst,            m_inst);
        check("cyc inst_pc",    bus.inst_pc,         m_ipc);
        check("cyc misalign",   32'(bus.misalign),   32'(m_mis));
        if (rst_n) begin
            if (m_boot) begin
                m_boot = 1'b0;
                m_req  = 1'b1;
            end else if (m_req) begin
                m_req = 1'b0;
                m_out = 1'b1;
            end else if (m_out) begin
                if (bus.imem_rvalid) begin
                    m_out   = 1'b0;
                    m_valid = 1'b1;
                    m_inst  = bus.imem_rdata;
                    m_ipc   = m_pc;
                end
            end else if (m_valid && bus.inst_ready) begin
                m_valid = 1'b0;
                if (bus.pcjump) begin
                    m_pc = model_target(bus.jump_target);
                    if (model_traps(bus.jump_target)) m_mis = 1'b1;
                    else                              m_req = 1'b1;
                end else begin
                    m_pc  = m_pc + 32'd4;
                    m_req = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        int n = 0;
        while (!bus.imem_req && n < 40) begin
            tick();
            n++;
        end
        check({name, " req"}, 32'(bus.imem_req), 32'd1);
        check({name, " addr"}, bus.imem_addr, exp_addr);
    endtask

    // Called in the ISSUE cycle (lat>=1) or in WAIT (lat=0); returns in HOLD.
    task automatic respond(input int lat, input logic [31:0] data);
        for (int i = 0; i < lat; i++) tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        tick();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
    endtask

    task automatic handshake(input logic jump, input logic [31:0] target);
        bus.inst_ready  = 1'b1;
        bus.pcjump      = jump;
        bus.jump_target = target;
        tick();
        bus.inst_ready  = 1'b0;
        bus.pcjump      = 1'b1;
        bus.jump_target = 32'h5555_5557;
    endtask

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.inst_ready  = 1'b0;
        bus.pcjump      = 1'b0;
        bus.jump_target = 32'h0;

        // Reset state, then BOOT for one cycle, then a single-cycle request.
        tick(); tick(); tick();
        check("rst imem_req",   32'(bus.imem_req),   32'd0);
        check("rst inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst inst",       bus.inst,            32'h0);
        check("rst inst_pc",    bus.inst_pc,         32'h0);
        check("rst misalign",   32'(bus.misalign),   32'd0);
        check("rst imem_addr",  bus.imem_addr,       32'h100);
        rst_n = 1'b1;
        #1;
        check("boot imem_req", 32'(bus.imem_req), 32'd0);
        tick();
        check("first req", 32'(bus.imem_req), 32'd1);
        check("first addr", bus.imem_addr, 32'h100);

        // Two-cycle memory latency, sequential fetch.
        respond(2, 32'h0050_0093);
        check("t2 inst_valid", 32'(bus.inst_valid), 32'd1);
        check("t2 inst",       bus.inst,            32'h0050_0093);
        check("t2 inst_pc",    bus.inst_pc,         32'h100);
        handshake(1'b0, 32'h0);
        check("t2 req after hs", 32'(bus.imem_req), 32'd1);
        check("t2 addr", bus.imem_addr, 32'h104);

        // Redirect clears low bits; sequential wrap at the top of memory.
        respond(1, 32'h0000_0013);
        check("t3 inst_pc", bus.inst_pc, 32'h104);
        handshake(1'b1, 32'h0000_0201);
        wait_req("t3 jump", 32'h200);
        respond(1, 32'h0000_0013);
        handshake(1'b1, 32'hFFFF_FFFC);
        wait_req("t3 top", 32'hFFFF_FFFC);
        respond(1, 32'h0000_0013);
        handshake(1'b0, 32'h0);
        wait_req("t3 wrap", 32'h0);

        // Stall in HOLD with a stray rvalid pulse.
        respond(1, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = 32'hBAD0_BAD0;
            end
            tick();
            bus.imem_rvalid = 1'b0;
            check("t4 inst",     bus.inst,          32'h1234_5678);
            check("t4 inst_pc",  bus.inst_pc,       32'h0);
            check("t4 imem_req", 32'(bus.imem_req), 32'd0);
        end
        handshake(1'b0, 32'h0);
        wait_req("t4 next", 32'h4);

        // Jump to an address with bit 1 set.
        respond(1, 32'h0000_0067);
        handshake(1'b1, 32'h0000_0202);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("t5 misalign", 32'(bus.misalign), 32'd1);
        check("t5 pc kept",  bus.imem_addr,     32'h202);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5 no req", 32'(bus.imem_req), 32'd0);
        end
`else
        check("t5 misalign", 32'(bus.misalign), 32'd0);
        wait_req("t5 jump", 32'h200);
        respond(1, 32'h0000_0013);
`endif

        // Async reset takes effect mid-cycle.
        if (!bus.inst_valid) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            wait_req("t6 pre", 32'h100);
            respond(1, 32'h0000_0013);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("t6 async valid", 32'(bus.inst_valid), 32'd0);
        check("t6 async inst",  bus.inst,            32'h0);
        tick();
        rst_n = 1'b1;
        wait_req("t6 restart", 32'h100);

        // Reset during WAIT, stray response in BOOT and ISSUE.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hCAFE_F00D;
        tick();
        check("t6 req after rst", 32'(bus.imem_req), 32'd1);
        check("t6 addr after rst", bus.imem_addr, 32'h100);
        tick();
        bus.imem_rvalid = 1'b0;
        check("t6 stray ignored", 32'(bus.inst_valid), 32'd0);
        check("t6 inst clear",    bus.inst,            32'h0);
        respond(0, 32'h0000_0513);
        check("t6 inst",    bus.inst,    32'h0000_0513);
        check("t6 inst_pc", bus.inst_pc, 32'h100);
        handshake(1'b0, 32'h0);
        wait_req("t6 seq", 32'h104);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
